// File: rtl/decode_pkg.sv
// Shared encodings for the handshaked decode stage: opcodes, functs, ALU codes,
// forward selects and the bundled control word.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_MEM    = 2'd1,
    FWD_WB     = 2'd2,
    FWD_RF_ALT = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_write;
    logic      mem_to_reg;
    logic      alu_src;
    logic      reg_dst;
    logic      branch;
    logic      jump;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/reg_file_bypass.sv
// Register file with synchronous clear, reg 0 hard-wired to zero and a
// write-first bypass so a same-cycle WB write is visible to decode reads.
module reg_file_bypass #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2
);

  localparam int DEPTH = 2 ** REG_AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;

  assign wr_en = we & (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Reg 0 check comes first so a (suppressed) write to $0 never bypasses.
  assign rdata1 = (raddr1 == '0) ? '0 :
                  (wr_en && (waddr == raddr1)) ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 :
                  (wr_en && (waddr == raddr2)) ? wdata : mem[raddr2];

endmodule

// File: rtl/decode_stage_hs.sv
// MIPS decode stage with valid/ready IF/ID register, bypassed register file,
// main control, 3-way forwarding and early BEQ/BNE/J resolution.
module decode_stage_hs
  import decode_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              DS_CLK,
  input  logic              DS_RST,
  input  logic [WIDTH-1:0]  DS_InstrF,
  input  logic [WIDTH-1:0]  DS_PCPLUS4F,
  input  logic              DS_ValidF,
  output logic              DS_ReadyD,
  output logic              DS_ValidD,
  input  logic              DS_ReadyE,
  input  logic              DS_StallD,
  input  logic [WIDTH-1:0]  DS_ALUOUTM,
  input  logic [WIDTH-1:0]  DS_ResultW,
  input  logic [REG_AW-1:0] DS_WriteRegW,
  input  logic              DS_RegWriteW,
  input  logic [1:0]        DS_ForwardAD,
  input  logic [1:0]        DS_ForwardBD,
  output logic [REG_AW-1:0] DS_RsD,
  output logic [REG_AW-1:0] DS_RtD,
  output logic [REG_AW-1:0] DS_RdD,
  output logic [WIDTH-1:0]  DS_R1,
  output logic [WIDTH-1:0]  DS_R2,
  output logic [WIDTH-1:0]  DS_SignImmD,
  output logic [WIDTH-1:0]  DS_PcBranchD,
  output logic [WIDTH-1:0]  DS_PcJumpD,
  output logic [1:0]        DS_PcSrc,
  output logic              DS_RegWriteD,
  output logic              DS_MemWriteD,
  output logic              DS_MemToRegD,
  output logic              DS_AluSrcD,
  output logic              DS_RegDstD,
  output logic              DS_BranchD,
  output logic              DS_JumpD,
  output logic [2:0]        DS_ALuControlD
);

  function automatic logic signed [WIDTH-1:0] sign_ext16(input logic [15:0] imm);
    return $signed({{(WIDTH-16){imm[15]}}, imm});
  endfunction

  function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] rf,
                                               input logic [WIDTH-1:0] mem,
                                               input logic [WIDTH-1:0] wb);
    case (sel)
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return rf;
    endcase
  endfunction

  logic [WIDTH-1:0]        instr_p1;
  logic [WIDTH-1:0]        pcplus4_p1;
  logic                    vld_p1;
  logic                    fire;
  logic                    accept;
  logic                    redirect;
  logic                    br_taken;
  logic [5:0]              op;
  logic [5:0]              funct;
  ctrl_t                   ctrl;
  ctrl_t                   ctrl_q;
  logic [WIDTH-1:0]        rf_rd1;
  logic [WIDTH-1:0]        rf_rd2;
  logic signed [WIDTH-1:0] sign_imm;
  logic                    unused_bits;

  assign fire      = vld_p1 & ~DS_StallD & DS_ReadyE;
  assign DS_ReadyD = ~vld_p1 | fire;
  assign accept    = DS_ValidF & DS_ReadyD;
  assign redirect  = |DS_PcSrc;

  // F -> D boundary: a redirect flushes whatever fetch is presenting.
  always_ff @(posedge DS_CLK) begin
    if (DS_RST) begin
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
      pcplus4_p1 <= '0;
    end else if (redirect) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      instr_p1   <= DS_InstrF;
      pcplus4_p1 <= DS_PCPLUS4F;
    end else if (fire) begin
      vld_p1 <= 1'b0;
    end
  end

  assign op     = instr_p1[31:26];
  assign funct  = instr_p1[5:0];
  assign DS_RsD = REG_AW'(instr_p1[25:21]);
  assign DS_RtD = REG_AW'(instr_p1[20:16]);
  assign DS_RdD = REG_AW'(instr_p1[15:11]);
  assign unused_bits = ^instr_p1;

  reg_file_bypass #(
    .WIDTH  (WIDTH),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk    (DS_CLK),
    .rst    (DS_RST),
    .we     (DS_RegWriteW),
    .waddr  (DS_WriteRegW),
    .wdata  (DS_ResultW),
    .raddr1 (DS_RsD),
    .raddr2 (DS_RtD),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  assign DS_R1 = fwd_mux(DS_ForwardAD, rf_rd1, DS_ALUOUTM, DS_ResultW);
  assign DS_R2 = fwd_mux(DS_ForwardBD, rf_rd2, DS_ALUOUTM, DS_ResultW);

  // Unsupported R-type functs decode like unknown opcodes, so sll $0 is a true nop.
  always_comb begin
    ctrl = CTRL_NONE;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl.alu_ctrl = ALU_AND;
          FN_OR:   ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
          default: ctrl = CTRL_NONE;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_J: ctrl.jump = 1'b1;
      default: ctrl = CTRL_NONE;
    endcase
  end

  assign ctrl_q = vld_p1 ? ctrl : CTRL_NONE;

  assign DS_ValidD      = vld_p1;
  assign DS_RegWriteD   = ctrl_q.reg_write;
  assign DS_MemWriteD   = ctrl_q.mem_write;
  assign DS_MemToRegD   = ctrl_q.mem_to_reg;
  assign DS_AluSrcD     = ctrl_q.alu_src;
  assign DS_RegDstD     = ctrl_q.reg_dst;
  assign DS_BranchD     = ctrl_q.branch;
  assign DS_JumpD       = ctrl_q.jump;
  assign DS_ALuControlD = ctrl_q.alu_ctrl;

  assign sign_imm     = sign_ext16(instr_p1[15:0]);
  assign DS_SignImmD  = sign_imm;
  assign DS_PcBranchD = pcplus4_p1 + $unsigned(sign_imm <<< 2);
  assign DS_PcJumpD   = WIDTH'({pcplus4_p1[31:28], instr_p1[25:0], 2'b00});

  // Redirects only leave decode in the cycle the instruction actually moves on.
  assign br_taken = ((op == OP_BEQ) && (DS_R1 == DS_R2)) ||
                    ((op == OP_BNE) && (DS_R1 != DS_R2));
  assign DS_PcSrc = fire ? {ctrl.jump, br_taken} : 2'b00;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: reset, bypass, branches, forwarding,
// back-pressure, stall and jump, with hand-computed expectations.
module tb_decode_stage_hs;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;

  logic              DS_CLK = 1'b0;
  logic              DS_RST;
  logic [WIDTH-1:0]  DS_InstrF;
  logic [WIDTH-1:0]  DS_PCPLUS4F;
  logic              DS_ValidF;
  logic              DS_ReadyD;
  logic              DS_ValidD;
  logic              DS_ReadyE;
  logic              DS_StallD;
  logic [WIDTH-1:0]  DS_ALUOUTM;
  logic [WIDTH-1:0]  DS_ResultW;
  logic [REG_AW-1:0] DS_WriteRegW;
  logic              DS_RegWriteW;
  logic [1:0]        DS_ForwardAD;
  logic [1:0]        DS_ForwardBD;
  logic [REG_AW-1:0] DS_RsD, DS_RtD, DS_RdD;
  logic [WIDTH-1:0]  DS_R1, DS_R2, DS_SignImmD, DS_PcBranchD, DS_PcJumpD;
  logic [1:0]        DS_PcSrc;
  logic              DS_RegWriteD, DS_MemWriteD, DS_MemToRegD, DS_AluSrcD;
  logic              DS_RegDstD, DS_BranchD, DS_JumpD;
  logic [2:0]        DS_ALuControlD;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 DS_CLK = ~DS_CLK;

  decode_stage_hs #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .DS_CLK(DS_CLK), .DS_RST(DS_RST), .DS_InstrF(DS_InstrF), .DS_PCPLUS4F(DS_PCPLUS4F),
    .DS_ValidF(DS_ValidF), .DS_ReadyD(DS_ReadyD), .DS_ValidD(DS_ValidD), .DS_ReadyE(DS_ReadyE),
    .DS_StallD(DS_StallD), .DS_ALUOUTM(DS_ALUOUTM), .DS_ResultW(DS_ResultW),
    .DS_WriteRegW(DS_WriteRegW), .DS_RegWriteW(DS_RegWriteW), .DS_ForwardAD(DS_ForwardAD),
    .DS_ForwardBD(DS_ForwardBD), .DS_RsD(DS_RsD), .DS_RtD(DS_RtD), .DS_RdD(DS_RdD),
    .DS_R1(DS_R1), .DS_R2(DS_R2), .DS_SignImmD(DS_SignImmD), .DS_PcBranchD(DS_PcBranchD),
    .DS_PcJumpD(DS_PcJumpD), .DS_PcSrc(DS_PcSrc), .DS_RegWriteD(DS_RegWriteD),
    .DS_MemWriteD(DS_MemWriteD), .DS_MemToRegD(DS_MemToRegD), .DS_AluSrcD(DS_AluSrcD),
    .DS_RegDstD(DS_RegDstD), .DS_BranchD(DS_BranchD), .DS_JumpD(DS_JumpD),
    .DS_ALuControlD(DS_ALuControlD)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge DS_CLK);
    #1;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc4);
    DS_InstrF   = ins;
    DS_PCPLUS4F = pc4;
    DS_ValidF   = 1'b1;
    step();
    DS_ValidF = 1'b0;
  endtask

  task automatic wb(input logic [REG_AW-1:0] r, input logic [31:0] v);
    DS_RegWriteW = 1'b1;
    DS_WriteRegW = r;
    DS_ResultW   = v;
    step();
    DS_RegWriteW = 1'b0;
  endtask

  initial begin
    DS_RST = 1'b1; DS_InstrF = '0; DS_PCPLUS4F = '0; DS_ValidF = 1'b0;
    DS_ReadyE = 1'b1; DS_StallD = 1'b0; DS_ALUOUTM = '0; DS_ResultW = '0;
    DS_WriteRegW = '0; DS_RegWriteW = 1'b0; DS_ForwardAD = 2'd0; DS_ForwardBD = 2'd0;

    // 1: reset
    step(); step();
    DS_RST = 1'b0;
    #1;
    chk("rst_valid",  32'(DS_ValidD), 32'd0);
    chk("rst_pcsrc",  32'(DS_PcSrc), 32'd0);
    chk("rst_ready",  32'(DS_ReadyD), 32'd1);
    chk("rst_ctrl",   32'({DS_RegWriteD, DS_MemWriteD, DS_MemToRegD, DS_AluSrcD,
                           DS_RegDstD, DS_BranchD, DS_JumpD, DS_ALuControlD}), 32'd0);

    // 2: write-first bypass and $0
    load(32'h00A03020, 32'h10);
    DS_RegWriteW = 1'b1; DS_WriteRegW = 5'd5; DS_ResultW = 32'h0000_1234;
    #1;
    chk("bypass_r1", DS_R1, 32'h0000_1234);
    chk("add_rs",    32'(DS_RsD), 32'd5);
    chk("add_rd",    32'(DS_RdD), 32'd6);
    chk("add_ctrl",  32'({DS_RegWriteD, DS_RegDstD, DS_AluSrcD, DS_ALuControlD}), 32'b11_0_010);
    step();
    DS_RegWriteW = 1'b0;
    load(32'h00A03020, 32'h14);
    #1;
    chk("stored_r5", DS_R1, 32'h0000_1234);
    DS_RegWriteW = 1'b1; DS_WriteRegW = 5'd0; DS_ResultW = 32'h0000_DEAD;
    load(32'h00003020, 32'h18);
    #1;
    chk("r0_bypass", DS_R1, 32'd0);
    DS_RegWriteW = 1'b0;

    // 3: BEQ taken, flush of the fetch presented alongside
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd7);
    load(32'h1022FFFF, 32'h100);
    DS_InstrF = 32'h00222020; DS_PCPLUS4F = 32'h104; DS_ValidF = 1'b1;
    #1;
    chk("beq_pcsrc",  32'(DS_PcSrc), 32'b01);
    chk("beq_target", DS_PcBranchD, 32'h0000_00FC);
    chk("beq_simm",   DS_SignImmD, 32'hFFFF_FFFF);
    chk("beq_ctrl",   32'({DS_BranchD, DS_ALuControlD}), 32'b1_110);
    step();
    DS_ValidF = 1'b0;
    #1;
    chk("beq_flush",  32'(DS_ValidD), 32'd0);

    // 4: BNE with forwarding; select 3 reads the register file
    wb(5'd3, 32'd3);
    DS_ForwardAD = 2'd1; DS_ALUOUTM = 32'd3;
    load(32'h14230000, 32'h200);
    #1;
    chk("bne_fwdm_pcsrc", 32'(DS_PcSrc), 32'b00);
    step();
    chk("bne_retired", 32'(DS_ValidD), 32'd0);
    DS_ForwardAD = 2'd2; DS_ResultW = 32'd4;
    load(32'h14230000, 32'h204);
    #1;
    chk("bne_fwdw_pcsrc", 32'(DS_PcSrc), 32'b01);
    chk("bne_target",     DS_PcBranchD, 32'h0000_0204);
    DS_ForwardAD = 2'd3;
    #1;
    chk("fwd3_is_rf", DS_R1, 32'd7);
    DS_ForwardAD = 2'd0;
    step();

    // 5: back-pressure, then simultaneous accept and fire
    DS_ReadyE = 1'b0;
    load(32'h00222020, 32'h300);
    DS_InstrF = 32'h20270005; DS_PCPLUS4F = 32'h304; DS_ValidF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(DS_ReadyD), 32'd0);
      chk("bp_hold",  32'({DS_ValidD, DS_RdD}), 32'({1'b1, 5'd4}));
      chk("bp_pcsrc", 32'(DS_PcSrc), 32'd0);
      step();
    end
    DS_ReadyE = 1'b1;
    #1;
    chk("bp_release_ready", 32'(DS_ReadyD), 32'd1);
    step();
    DS_ValidF = 1'b0;
    #1;
    chk("swap_valid", 32'(DS_ValidD), 32'd1);
    chk("addi_rt",    32'(DS_RtD), 32'd7);
    chk("addi_ctrl",  32'({DS_RegWriteD, DS_RegDstD, DS_AluSrcD, DS_ALuControlD}), 32'b10_1_010);
    step();

    // 6: jump held by hazard stall for one cycle
    DS_StallD = 1'b1;
    load(32'h08040000, 32'h9000_0004);
    #1;
    chk("j_stall_pcsrc", 32'(DS_PcSrc), 32'b00);
    chk("j_stall_ready", 32'(DS_ReadyD), 32'd0);
    chk("j_jumpd",       32'(DS_JumpD), 32'd1);
    DS_StallD = 1'b0;
    #1;
    chk("j_pcsrc",  32'(DS_PcSrc), 32'b10);
    chk("j_target", DS_PcJumpD, 32'h9010_0000);
    step();
    chk("j_retired", 32'(DS_ValidD), 32'd0);

    // unknown opcode decodes to no control
    load(32'hFC00FFFF, 32'h400);
    #1;
    chk("unk_valid", 32'(DS_ValidD), 32'd1);
    chk("unk_ctrl",  32'({DS_RegWriteD, DS_MemWriteD, DS_MemToRegD, DS_AluSrcD,
                          DS_RegDstD, DS_BranchD, DS_JumpD, DS_ALuControlD}), 32'd0);
    step();

    // reset mid-operation drops the instruction and clears the register file
    DS_ReadyE = 1'b0;
    load(32'h00222020, 32'h500);
    #1;
    chk("pre_rst_r1", DS_R1, 32'd7);
    DS_RST = 1'b1;
    step();
    DS_RST = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(DS_ValidD), 32'd0);
    chk("mid_rst_pcsrc", 32'(DS_PcSrc), 32'd0);
    DS_ReadyE = 1'b1;
    load(32'h00222020, 32'h504);
    #1;
    chk("rf_cleared", DS_R1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
